mailbox_fifo: RTL and testbench

// - Buffered one-way mailbox between two processor cores; neighbour of the single-register dropbox channel.
// - Side 1 (producer core) pushes bytes over its OUTBUS; side 2 (consumer core) pops them over its INBUS.
// - A DEPTH-entry FIFO replaces the single overwrite register, so back-to-back messages are not lost.
// - Status registers expose count, full/empty and sticky overflow/underflow to both cores.

---
 rtl/mailbox_fifo.sv | 120 ++++++++++++
 tb/tb_mailbox_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mailbox_fifo.sv
// Buffered one-way byte mailbox: side 1 pushes, side 2 pops, both can read status.
// Optional IRQ2 output (count != 0) when MAILBOX_FIFO_IRQ_EN is defined.
module mailbox_fifo #(
  parameter logic [7:0] DEVADDR1   = 8'h00,
  parameter logic [7:0] DEVADDR2   = 8'h00,
  parameter int         DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] OUTBUS_ADDR1,
  input  logic [7:0] OUTBUS_DATA1,
  input  logic       OUTBUS_WE1,
  input  logic [7:0] INBUS_ADDR1,
  output logic [7:0] INBUS_DATA1,
  input  logic       INBUS_RE1,
  input  logic [7:0] OUTBUS_ADDR2,
  input  logic [7:0] OUTBUS_DATA2,
  input  logic       OUTBUS_WE2,
  input  logic [7:0] INBUS_ADDR2,
  output logic [7:0] INBUS_DATA2,
  input  logic       INBUS_RE2
`ifdef MAILBOX_FIFO_IRQ_EN
  ,
  output logic       IRQ2
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [7:0] DATA1_ADDR = DEVADDR1;
  localparam logic [7:0] STAT1_ADDR = DEVADDR1 + 8'd1;
  localparam logic [7:0] DATA2_ADDR = DEVADDR2;
  localparam logic [7:0] STAT2_ADDR = DEVADDR2 + 8'd1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [7:0]    rdata1_q, rdata1_d;
  logic [7:0]    rdata2_q, rdata2_d;

  logic       push_req, pop_req, push_ok, pop_ok;
  logic       full, empty;
  logic       ovf_clr, unf_clr;
  logic [7:0] status;
  logic       unused_data2_bits;

  assign unused_data2_bits = ^{OUTBUS_DATA2[7], OUTBUS_DATA2[5:0]};

  always_comb begin
    push_req = OUTBUS_WE1 && (OUTBUS_ADDR1 == DATA1_ADDR);
    pop_req  = INBUS_RE2 && (INBUS_ADDR2 == DATA2_ADDR);
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop_req && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_ok  = push_req && (!full || pop_ok);
    ovf_clr  = OUTBUS_WE1 && (OUTBUS_ADDR1 == STAT1_ADDR) && OUTBUS_DATA1[7];
    unf_clr  = OUTBUS_WE2 && (OUTBUS_ADDR2 == STAT2_ADDR) && OUTBUS_DATA2[6];
    status   = {ovf_q, unf_q, full, empty, 4'(count_q)};

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d    = (push_req && !push_ok) || (ovf_q && !ovf_clr);
    unf_d    = (pop_req && empty) || (unf_q && !unf_clr);

    rdata1_d = '0;
    if (INBUS_RE1 && (INBUS_ADDR1 == STAT1_ADDR)) rdata1_d = status;

    rdata2_d = '0;
    if (INBUS_RE2 && (INBUS_ADDR2 == STAT2_ADDR)) rdata2_d = status;
    else if (pop_ok)                               rdata2_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= OUTBUS_DATA1;
  end

  assign INBUS_DATA1 = rdata1_q;
  assign INBUS_DATA2 = rdata2_q;

`ifdef MAILBOX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = (count_d != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign IRQ2 = irq_q;
`endif

endmodule

// File: tb/tb_mailbox_fifo.sv
// Bench for mailbox_fifo: directed vector table, wrap and reset sequences, random traffic vs queue model.
module tb_mailbox_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] oa1, od1, ia1, oa2, od2, ia2;
  logic       we1, re1, we2, re2;
  logic [7:0] id1, id2;
`ifdef MAILBOX_FIFO_IRQ_EN
  logic       irq2;
`endif

  always #5 clk = ~clk;

  mailbox_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .OUTBUS_ADDR1 (oa1),
    .OUTBUS_DATA1 (od1),
    .OUTBUS_WE1   (we1),
    .INBUS_ADDR1  (ia1),
    .INBUS_DATA1  (id1),
    .INBUS_RE1    (re1),
    .OUTBUS_ADDR2 (oa2),
    .OUTBUS_DATA2 (od2),
    .OUTBUS_WE2   (we2),
    .INBUS_ADDR2  (ia2),
    .INBUS_DATA2  (id2),
    .INBUS_RE2    (re2)
`ifdef MAILBOX_FIFO_IRQ_EN
    ,
    .IRQ2         (irq2)
`endif
  );

  typedef struct {
    logic       we1;
    logic [7:0] wa1, wd1;
    logic       re1;
    logic [7:0] ra1;
    logic       we2;
    logic [7:0] wa2, wd2;
    logic       re2;
    logic [7:0] ra2;
    logic [7:0] e1, e2;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a byte queue plus two sticky flags.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  function automatic vec_t mk(logic w1, logic [7:0] a1, logic [7:0] d1, logic r1, logic [7:0] b1,
                              logic w2, logic [7:0] a2, logic [7:0] d2, logic r2, logic [7:0] b2,
                              logic [7:0] x1, logic [7:0] x2);
    vec_t v;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1; v.re1 = r1; v.ra1 = b1;
    v.we2 = w2; v.wa2 = a2; v.wd2 = d2; v.re2 = r2; v.ra2 = b2;
    v.e1 = x1; v.e2 = x2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    int s = mq.size();
    return {m_ovf, m_unf, (s == 4), (s == 0), 4'(s)};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock cycle: predict with the model, drive, clock, compare.
  task automatic apply(input vec_t v, input bit use_tab, input string nm);
    logic [7:0] e1, e2;
    int  s0;
    bit  pushreq, popreq, popped, ovf_set, unf_set, ovf_clr, unf_clr;
    e1 = 8'h00;
    e2 = 8'h00;
    s0 = mq.size();
    if (v.re1 && v.ra1 == 8'h01) e1 = m_status();
    if (v.re2 && v.ra2 == 8'h01) e2 = m_status();
    pushreq = v.we1 && v.wa1 == 8'h00;
    popreq  = v.re2 && v.ra2 == 8'h00;
    popped  = popreq && s0 > 0;
    ovf_set = pushreq && !(s0 < 4 || popped);
    unf_set = popreq && s0 == 0;
    ovf_clr = v.we1 && v.wa1 == 8'h01 && v.wd1[7];
    unf_clr = v.we2 && v.wa2 == 8'h01 && v.wd2[6];
    if (popped) e2 = mq.pop_front();
    if (pushreq && !ovf_set) mq.push_back(v.wd1);
    m_ovf = ovf_set || (m_ovf && !ovf_clr);
    m_unf = unf_set || (m_unf && !unf_clr);

    we1 = v.we1; oa1 = v.wa1; od1 = v.wd1; re1 = v.re1; ia1 = v.ra1;
    we2 = v.we2; oa2 = v.wa2; od2 = v.wd2; re2 = v.re2; ia2 = v.ra2;
    @(posedge clk);
    #1;
    if (use_tab) begin
      chk({nm, "_d1"}, id1, v.e1);
      chk({nm, "_d2"}, id2, v.e2);
    end else begin
      chk({nm, "_d1"}, id1, e1);
      chk({nm, "_d2"}, id2, e2);
    end
`ifdef MAILBOX_FIFO_IRQ_EN
    chk({nm, "_irq"}, {7'd0, irq2}, {7'd0, mq.size() != 0});
`endif
    we1 = 0; re1 = 0; we2 = 0; re2 = 0;
  endtask

  vec_t tab[$];
  vec_t idle, push_v, pop_v, stat_v;

  initial begin
    reset = 1'b1;
    we1 = 0; re1 = 0; we2 = 0; re2 = 0;
    oa1 = 0; od1 = 0; ia1 = 0; oa2 = 0; od2 = 0; ia2 = 0;
    idle   = mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00);
    stat_v = mk(0,8'h00,8'h00, 1,8'h01, 0,8'h00,8'h00, 1,8'h01, 8'h10,8'h10);
    pop_v  = mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h00);

    tab.push_back(stat_v);
    tab.push_back(mk(1,8'h00,8'hA1, 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00));
    tab.push_back(mk(1,8'h00,8'hB2, 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00));
    tab.push_back(mk(1,8'h00,8'hC3, 1,8'h01, 0,8'h00,8'h00, 0,8'h00, 8'h02,8'h00));
    tab.push_back(mk(0,8'h00,8'h00, 1,8'h00, 0,8'h00,8'h00, 1,8'h01, 8'h00,8'h03));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'hA1));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'hB2));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'hC3));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h01, 8'h00,8'h10));
    for (int i = 1; i <= 5; i++)
      tab.push_back(mk(1,8'h00,8'(i*8'h11), 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00));
    tab.push_back(mk(0,8'h00,8'h00, 1,8'h01, 0,8'h00,8'h00, 0,8'h00, 8'hA4,8'h00));
    tab.push_back(mk(1,8'h01,8'h80, 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00));
    tab.push_back(mk(0,8'h00,8'h00, 1,8'h01, 0,8'h00,8'h00, 0,8'h00, 8'h24,8'h00));
    tab.push_back(mk(1,8'h00,8'h66, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h11));
    tab.push_back(mk(0,8'h00,8'h00, 1,8'h01, 0,8'h00,8'h00, 1,8'h01, 8'h24,8'h24));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h22));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h33));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h44));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h66));
    tab.push_back(pop_v);
    tab.push_back(mk(0,8'h00,8'h00, 1,8'h01, 0,8'h00,8'h00, 1,8'h01, 8'h50,8'h50));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 1,8'h01,8'h40, 0,8'h00, 8'h00,8'h00));
    tab.push_back(mk(1,8'h00,8'h77, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h00));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h01, 8'h00,8'h41));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h00, 8'h00,8'h77));
    // Underflow set and clear in the same cycle: set must win.
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 1,8'h01,8'h40, 1,8'h00, 8'h00,8'h00));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h01, 8'h00,8'h50));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 1,8'h01,8'h40, 0,8'h00, 8'h00,8'h00));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h01, 8'h00,8'h10));
    tab.push_back(mk(0,8'h00,8'h00, 0,8'h00, 1,8'h00,8'h99, 0,8'h00, 8'h00,8'h00));
    tab.push_back(stat_v);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_d1", id1, 8'h00);
    chk("rst_d2", id2, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    foreach (tab[i]) apply(tab[i], 1'b1, $sformatf("vec%0d", i));

    // Twelve pushes interleaved with pops walk the pointers round three times.
    for (int i = 0; i < 12; i++) begin
      push_v = mk(1,8'h00,8'(i*7+3), 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00);
      apply(push_v, 1'b1, $sformatf("wrap_push%0d", i));
      pop_v.e2 = 8'(i*7+3);
      apply(pop_v, 1'b1, $sformatf("wrap_pop%0d", i));
    end
    apply(stat_v, 1'b1, "wrap_stat");

    for (int i = 0; i < 600; i++) begin
      vec_t r;
      r = mk($urandom_range(0,1), 8'($urandom_range(0,2)), 8'($urandom),
             $urandom_range(0,3) == 0, 8'($urandom_range(0,2)),
             $urandom_range(0,7) == 0, 8'($urandom_range(0,2)), 8'($urandom),
             $urandom_range(0,2) == 0, 8'($urandom_range(0,2)), 8'h00, 8'h00);
      apply(r, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of traffic with a status read pending on the bus.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++)
      apply(mk(1,8'h00,8'(8'hE0+i), 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00), 1'b1, "mid_push");
    apply(mk(0,8'h00,8'h00, 0,8'h00, 0,8'h00,8'h00, 1,8'h01, 8'h00,8'h03), 1'b1, "mid_stat");
    #2 reset = 1'b1;
    #1;
    chk("async_rst_d2", id2, 8'h00);
`ifdef MAILBOX_FIFO_IRQ_EN
    chk("async_rst_irq", {7'd0, irq2}, 8'h00);
`endif
    @(negedge clk); reset = 1'b0;
    m_reset();
    apply(stat_v, 1'b1, "post_rst_stat");
    apply(mk(1,8'h00,8'h5A, 0,8'h00, 0,8'h00,8'h00, 0,8'h00, 8'h00,8'h00), 1'b1, "post_rst_push");
    apply(idle, 1'b1, "idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
